leak_diff_checker: RTL and testbench

- Reusable relational checker for constant-time verification of Sodor cores: two ISA (single-cycle) copies, two pipelined copies.
- Replaces hand-written per-top assume/assert pairs with one parametrised monitor.
- Supports NUM_CH observation channels (commit, dmem address, ...) and two compare modes:
  - Lockstep: same-cycle compare.
  - Commit-aligned: per-channel skew FIFOs absorb timing differences.
- Contract breach (ISA copies diverge) is latched as VOID rather than assumed away; leaks latch a sticky LEAK verdict.

---
 rtl/leak_chk_pkg.sv | 20 ++
 rtl/obs_skew_fifo.sv | 70 +++++++
 rtl/leak_diff_checker.sv | 183 ++++++++++++++++++
 tb/tb_leak_diff_checker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leak_chk_pkg.sv
// Shared types and constants for the relational leak checker.
// Imported by the checker top and its skew FIFO.
package leak_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    LEAK  = 2'd2,
    VOID  = 2'd3
  } chk_state_e;

  localparam int MODE_LOCKSTEP = 0;
  localparam int MODE_ALIGNED  = 1;

  // leak_ch carries one spare bit so all-ones never aliases a real channel
  function automatic int lch_w(input int num_ch);
    return $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/obs_skew_fifo.sv
// Skew FIFO for one channel of one copy in commit-aligned mode.
// Head bypasses a same-cycle push when empty.
module obs_skew_fifo
  import leak_chk_pkg::*;
#(
  parameter int OBS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [OBS_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [OBS_W-1:0] head_o,
  output logic             head_vld_o,
  output logic             ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [OBS_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             empty;
  logic             full;
  logic             byp;
  logic             wr_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW])
              && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign head_vld_o = !empty || push_i;
  assign head_o     = empty ? push_data_i
                            : mem_q[rd_q[AW-1:0]];

  assign ovf_o = push_i && full && !pop_i;

  // A bypassed push is consumed by the pop and never stored
  assign byp   = empty && push_i && pop_i;
  assign wr_en = push_i && !byp && !ovf_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop_i && !empty) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/leak_diff_checker.sv
// Relational constant-time checker over two ISA and two impl copies.
// Latches VOID on contract breach, sticky LEAK with first-leak info.
module leak_diff_checker
  import leak_chk_pkg::*;
#(
  parameter int OBS_W  = 32,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    isa_valid_a,
  input  logic                    isa_valid_b,
  input  logic [OBS_W-1:0]        isa_obs_a,
  input  logic [OBS_W-1:0]        isa_obs_b,
  input  logic [NUM_CH-1:0]       impl_valid_a,
  input  logic [NUM_CH-1:0]       impl_valid_b,
  input  logic [NUM_CH*OBS_W-1:0] impl_obs_a,
  input  logic [NUM_CH*OBS_W-1:0] impl_obs_b,
  output logic [1:0]              state,
  output logic                    leak,
  output logic                    void_run,
  output logic [$clog2(NUM_CH):0] leak_ch,
  output logic                    leak_ovf,
  output logic [CNT_W-1:0]        leak_cycle
);

  localparam int LCH_W = lch_w(NUM_CH);
  localparam logic [LCH_W-1:0] CH_NONE = '1;

  chk_state_e       state_q, state_d;
  logic             leak_q, leak_d;
  logic             void_q, void_d;
  logic             ovf_q, ovf_d;
  logic [LCH_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              in_check;
  logic              breach;
  logic [NUM_CH-1:0] ch_leak;
  logic [NUM_CH-1:0] ch_ovf;
  logic              any_leak;
  logic [LCH_W-1:0]  sel_ch;
  logic              sel_ovf;

  assign in_check = (state_q == CHECK);

  assign breach = in_check
    && ((isa_valid_a != isa_valid_b)
     || (isa_valid_a && (isa_obs_a != isa_obs_b)));

  if (MODE == MODE_ALIGNED) begin : g_aligned
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [OBS_W-1:0] head_a, head_b;
      logic             hv_a, hv_b;
      logic             ovf_a, ovf_b;
      logic             pop;

      assign pop = in_check && hv_a && hv_b;

      obs_skew_fifo #(
        .OBS_W (OBS_W),
        .DEPTH (DEPTH)
      ) u_fifo_a (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_check && impl_valid_a[k]),
        .push_data_i (impl_obs_a[k*OBS_W +: OBS_W]),
        .pop_i       (pop),
        .head_o      (head_a),
        .head_vld_o  (hv_a),
        .ovf_o       (ovf_a)
      );

      obs_skew_fifo #(
        .OBS_W (OBS_W),
        .DEPTH (DEPTH)
      ) u_fifo_b (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_check && impl_valid_b[k]),
        .push_data_i (impl_obs_b[k*OBS_W +: OBS_W]),
        .pop_i       (pop),
        .head_o      (head_b),
        .head_vld_o  (hv_b),
        .ovf_o       (ovf_b)
      );

      assign ch_ovf[k]  = ovf_a || ovf_b;
      assign ch_leak[k] = (pop && (head_a != head_b))
                       || ch_ovf[k];
    end
  end else begin : g_lockstep
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [OBS_W-1:0] eff_a, eff_b;

      assign eff_a = impl_valid_a[k]
                   ? impl_obs_a[k*OBS_W +: OBS_W] : '0;
      assign eff_b = impl_valid_b[k]
                   ? impl_obs_b[k*OBS_W +: OBS_W] : '0;

      assign ch_ovf[k]  = 1'b0;
      assign ch_leak[k] = (impl_valid_a[k] != impl_valid_b[k])
                       || (eff_a != eff_b);
    end
  end

  assign any_leak = |ch_leak;

  // Walk downward so the lowest leaking channel wins
  always_comb begin
    sel_ch  = CH_NONE;
    sel_ovf = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_leak[k]) begin
        sel_ch  = LCH_W'(k);
        sel_ovf = ch_ovf[k];
      end
    end
  end

  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    leak_d  = leak_q;
    void_d  = void_q;
    ch_d    = ch_q;
    ovf_d   = ovf_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (breach) begin
          state_d = VOID;
          void_d  = 1'b1;
        end else if (any_leak) begin
          state_d = LEAK;
          leak_d  = 1'b1;
          ch_d    = sel_ch;
          ovf_d   = sel_ovf;
          cyc_d   = cnt_q;
        end
      end
      LEAK, VOID: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      leak_q  <= 1'b0;
      void_q  <= 1'b0;
      ch_q    <= CH_NONE;
      ovf_q   <= 1'b0;
      cyc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      leak_q  <= leak_d;
      void_q  <= void_d;
      ch_q    <= ch_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state      = state_q;
  assign leak       = leak_q;
  assign void_run   = void_q;
  assign leak_ch    = ch_q;
  assign leak_ovf   = ovf_q;
  assign leak_cycle = cyc_q;

endmodule

// File: tb/tb_leak_diff_checker.sv
// Directed scoreboard bench: lockstep and commit-aligned instances
// share stimulus; expectations are queued per cycle and popped after the edge.
module tb_leak_diff_checker;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_LEAK  = 2'd2;
  localparam logic [1:0] S_VOID  = 2'd3;
  localparam logic [1:0] NONE    = 2'd3;

  typedef struct {
    int          inst;
    logic [1:0]  st;
    logic        lk;
    logic        vd;
    logic [1:0]  ch;
    logic        ov;
    logic [31:0] cy;
  } exp_t;

  exp_t exq[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        isa_valid_a, isa_valid_b;
  logic [31:0] isa_obs_a, isa_obs_b;
  logic [1:0]  iva, ivb;
  logic [63:0] ioa, iob;

  logic [1:0]  st0, st1;
  logic        lk0, lk1, vd0, vd1, ov0, ov1;
  logic [1:0]  ch0, ch1;
  logic [31:0] cy0, cy1;

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  leak_diff_checker #(
    .OBS_W(32), .NUM_CH(2), .DEPTH(4), .MODE(0), .CNT_W(32)
  ) u_ls (
    .clk(clk), .rst(rst),
    .isa_valid_a(isa_valid_a), .isa_valid_b(isa_valid_b),
    .isa_obs_a(isa_obs_a), .isa_obs_b(isa_obs_b),
    .impl_valid_a(iva), .impl_valid_b(ivb),
    .impl_obs_a(ioa), .impl_obs_b(iob),
    .state(st0), .leak(lk0), .void_run(vd0),
    .leak_ch(ch0), .leak_ovf(ov0), .leak_cycle(cy0)
  );

  leak_diff_checker #(
    .OBS_W(32), .NUM_CH(2), .DEPTH(4), .MODE(1), .CNT_W(32)
  ) u_al (
    .clk(clk), .rst(rst),
    .isa_valid_a(isa_valid_a), .isa_valid_b(isa_valid_b),
    .isa_obs_a(isa_obs_a), .isa_obs_b(isa_obs_b),
    .impl_valid_a(iva), .impl_valid_b(ivb),
    .impl_obs_a(ioa), .impl_obs_b(iob),
    .state(st1), .leak(lk1), .void_run(vd1),
    .leak_ch(ch1), .leak_ovf(ov1), .leak_cycle(cy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string tag, int inst,
                     logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s inst%0d cyc%0d observed=%0h expected=%0h",
             tag, inst, cyc, obs, expv);
    end
  endtask

  task automatic expect_o(int inst, logic [1:0] st, logic lk,
                          logic vd, logic [1:0] ch, logic ov,
                          logic [31:0] cy);
    exp_t e;
    e.inst = inst; e.st = st; e.lk = lk; e.vd = vd;
    e.ch = ch; e.ov = ov; e.cy = cy;
    exq.push_back(e);
  endtask

  task automatic exp_ok(int inst);
    expect_o(inst, S_CHECK, 0, 0, NONE, 0, 0);
  endtask

  task automatic exp_leak(int inst, logic [1:0] ch, logic ov, int c);
    expect_o(inst, S_LEAK, 1, 0, ch, ov, 32'(c));
  endtask

  task automatic exp_void(int inst);
    expect_o(inst, S_VOID, 0, 1, NONE, 0, 0);
  endtask

  task automatic check_all(string tag);
    exp_t e;
    logic [1:0] s, c;
    logic l, v, o;
    logic [31:0] y;
    while (exq.size() > 0) begin
      e = exq.pop_front();
      if (e.inst == 0) begin
        s = st0; l = lk0; v = vd0; c = ch0; o = ov0; y = cy0;
      end else begin
        s = st1; l = lk1; v = vd1; c = ch1; o = ov1; y = cy1;
      end
      chk({tag, ".state"}, e.inst, 32'(s), 32'(e.st));
      chk({tag, ".leak"}, e.inst, 32'(l), 32'(e.lk));
      chk({tag, ".void"}, e.inst, 32'(v), 32'(e.vd));
      chk({tag, ".leak_ch"}, e.inst, 32'(c), 32'(e.ch));
      chk({tag, ".leak_ovf"}, e.inst, 32'(o), 32'(e.ov));
      chk({tag, ".leak_cycle"}, e.inst, y, e.cy);
    end
  endtask

  task automatic clear_in();
    isa_valid_a = 0; isa_valid_b = 0;
    isa_obs_a = '0; isa_obs_b = '0;
    iva = '0; ivb = '0; ioa = '0; iob = '0;
  endtask

  task automatic set_ch(int k, logic va, logic [31:0] oa,
                        logic vb, logic [31:0] ob);
    iva[k] = va; ivb[k] = vb;
    ioa[k*32 +: 32] = oa;
    iob[k*32 +: 32] = ob;
  endtask

  task automatic rand_same();
    logic v;
    logic [31:0] o;
    clear_in();
    v = 1'($urandom_range(0, 1));
    o = $urandom;
    isa_valid_a = v; isa_valid_b = v;
    isa_obs_a = o; isa_obs_b = o;
    for (int k = 0; k < 2; k++) begin
      v = 1'($urandom_range(0, 1));
      o = $urandom;
      set_ch(k, v, o, v, o);
    end
  endtask

  task automatic do_reset(string tag);
    clear_in();
    rst = 1;
    step();
    step();
    rst = 0;
    cyc = 0;
    expect_o(0, S_IDLE, 0, 0, NONE, 0, 0);
    expect_o(1, S_IDLE, 0, 0, NONE, 0, 0);
    check_all(tag);
  endtask

  initial begin
    rst = 1;
    clear_in();

    // lockstep leak at cycle 20 on ch1
    do_reset("rst1");
    for (int c = 0; c < 50; c++) begin
      rand_same();
      if (c == 20) begin
        set_ch(1, 1, 32'h100, 1, 32'h104);
      end
      if (c < 20) begin
        exp_ok(0); exp_ok(1);
      end else begin
        exp_leak(0, 1, 0, 20); exp_leak(1, 1, 0, 20);
      end
      step();
      check_all("ls_leak");
    end

    // copy B lags copy A by 3 cycles with equal values
    do_reset("rst2");
    for (int c = 0; c < 10; c++) begin
      clear_in();
      if (c >= 2 && c <= 4) set_ch(0, 1, 32'(16 * (c - 1)), 0, 0);
      if (c >= 5 && c <= 7) set_ch(0, 0, 0, 1, 32'(16 * (c - 4)));
      if (c < 2) exp_ok(0); else exp_leak(0, 0, 0, 2);
      exp_ok(1);
      step();
      check_all("skew3");
    end

    // delayed mismatch in aligned mode
    do_reset("rst3");
    for (int c = 0; c < 7; c++) begin
      clear_in();
      if (c == 2) set_ch(0, 1, 32'h10, 0, 0);
      if (c == 4) set_ch(0, 0, 0, 1, 32'h11);
      if (c < 2) exp_ok(0); else exp_leak(0, 0, 0, 2);
      if (c < 4) exp_ok(1); else exp_leak(1, 0, 0, 4);
      step();
      check_all("skew_mm");
    end

    // push plus pop on a full FIFO is legal
    do_reset("rst4");
    for (int c = 0; c < 13; c++) begin
      clear_in();
      if (c >= 1 && c <= 5) begin
        iva[0] = 1; ioa[31:0] = 32'(8'hA0 + c);
      end
      if (c >= 5 && c <= 9) begin
        ivb[0] = 1; iob[31:0] = 32'(8'hA0 + c - 4);
      end
      if (c < 1) exp_ok(0); else exp_leak(0, 0, 0, 1);
      exp_ok(1);
      step();
      check_all("full_pp");
    end

    // overflow on the fifth unmatched push
    do_reset("rst5");
    for (int c = 0; c < 6; c++) begin
      clear_in();
      if (c >= 1) set_ch(0, 1, 32'(8'hC0 + c), 0, 0);
      if (c < 1) exp_ok(0); else exp_leak(0, 0, 0, 1);
      if (c < 5) exp_ok(1); else exp_leak(1, 0, 1, 5);
      step();
      check_all("ovf");
    end

    // one-cycle reset from LEAK
    clear_in();
    rst = 1;
    expect_o(0, S_IDLE, 0, 0, NONE, 0, 0);
    expect_o(1, S_IDLE, 0, 0, NONE, 0, 0);
    step();
    check_all("mid_rst");
    rst = 0;
    cyc = 0;
    for (int c = 0; c < 2; c++) begin
      exp_ok(0); exp_ok(1);
      step();
      check_all("post_rst");
    end

    // breach and leak in the same cycle: VOID wins
    do_reset("rst6");
    for (int c = 0; c < 6; c++) begin
      clear_in();
      if (c == 3) begin
        isa_valid_a = 1; isa_valid_b = 1;
        isa_obs_a = 32'h40; isa_obs_b = 32'h44;
        set_ch(0, 1, 32'h1, 1, 32'h2);
      end
      if (c < 3) begin
        exp_ok(0); exp_ok(1);
      end else begin
        exp_void(0); exp_void(1);
      end
      step();
      check_all("void_obs");
    end

    // valid-only breach; same breach in IDLE is ignored
    do_reset("rst7");
    for (int c = 0; c < 3; c++) begin
      clear_in();
      if (c <= 1) isa_valid_a = 1;
      if (c < 1) begin
        exp_ok(0); exp_ok(1);
      end else begin
        exp_void(0); exp_void(1);
      end
      step();
      check_all("void_vld");
    end

    // mismatching events during IDLE are never pushed
    do_reset("rst8");
    for (int c = 0; c < 3; c++) begin
      clear_in();
      if (c == 0) set_ch(0, 1, 32'h99, 1, 32'h77);
      if (c == 1) set_ch(0, 1, 32'h55, 1, 32'h55);
      exp_ok(0); exp_ok(1);
      step();
      check_all("idle_ign");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
